// File: rtl/register_file_mp_pkg.sv
// Shared definitions for the multi-port register file.
//   DEFAULT_DATA_WIDTH / DEFAULT_SEL_WIDTH : default register and select widths
//   ZERO_INDEX                             : index of the hardwired-zero register
//   state_e                                : clear sequencer states
//   reg_valid()                            : true when an index names real, writable storage
package register_file_mp_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_SEL_WIDTH  = 5;
  localparam int ZERO_INDEX         = 0;

  typedef enum logic [0:0] {
    STATE_CLEAR = 1'b0,
    STATE_READY = 1'b1
  } state_e;

  // An index is usable when it is inside the array and is not the
  // hardwired-zero register (when that register exists).
  function automatic logic reg_valid(input int idx, input int num_regs, input logic zero_reg);
    return (idx < num_regs) && !(zero_reg && (idx == ZERO_INDEX));
  endfunction

endpackage

// File: rtl/register_scoreboard.sv
// Per-register pending bits used for pipeline hazard detection.
//   clock_i, reset_i   : clock and asynchronous active-high reset
//   set_en_i/set_sel_i : mark a register pending (already qualified by the caller)
//   clr_en_i/clr_sel_i : clear a register's pending bit on an accepted write
//   read_sel_i         : packed per-port selects
//   pending_o          : registered pending bit of each port's selected register
module register_scoreboard
  import register_file_mp_pkg::*;
#(
  parameter int NUM_REGS  = 31,
  parameter int SEL_WIDTH = DEFAULT_SEL_WIDTH,
  parameter int NUM_READ  = 3
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          set_en_i,
  input  logic [SEL_WIDTH-1:0]          set_sel_i,
  input  logic                          clr_en_i,
  input  logic [SEL_WIDTH-1:0]          clr_sel_i,
  input  logic [NUM_READ*SEL_WIDTH-1:0] read_sel_i,
  output logic [NUM_READ-1:0]           pending_o
);

  localparam int SEL_SPAN = 2 ** SEL_WIDTH;

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [SEL_SPAN-1:0] pending_ext;

  // Clear first, then set: a reservation issued in the same cycle as the
  // write that retires the previous one is the newer producer and must win.
  always_comb begin
    pending_d = pending_q;
    if (clr_en_i) pending_d[clr_sel_i] = 1'b0;
    if (set_en_i) pending_d[set_sel_i] = 1'b1;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) pending_q <= '0;
    else         pending_q <= pending_d;
  end

  // Widened copy so out-of-range selects look up a constant 0.
  always_comb begin
    pending_ext                 = '0;
    pending_ext[NUM_REGS-1:0]   = pending_q;
    for (int k = 0; k < NUM_READ; k++) begin
      pending_o[k] = pending_ext[read_sel_i[k*SEL_WIDTH +: SEL_WIDTH]];
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file with one write port, optional write-to-read
// bypass, a pending scoreboard and a post-reset clear sequencer.
//   clock_i, reset_i  : clock and asynchronous active-high reset
//   read_sel_i        : packed read selects, NUM_READ x SEL_WIDTH
//   read_value_o      : packed combinational read data, NUM_READ x DATA_WIDTH
//   read_pending_o    : selected register has an outstanding reservation
//   write_enable_i, select_write_i, write_value_i : synchronous write port
//   reserve_enable_i, reserve_sel_i               : scoreboard reservation
//   busy_o            : clear sequencer running; writes/reservations ignored
module register_file_mp
  import register_file_mp_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int NUM_REGS       = 31,
  parameter int SEL_WIDTH      = DEFAULT_SEL_WIDTH,
  parameter int NUM_READ       = 3,
  parameter int BYPASS         = 1,
  parameter int ZERO_REG       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic [NUM_READ*SEL_WIDTH-1:0]  read_sel_i,
  output logic [NUM_READ*DATA_WIDTH-1:0] read_value_o,
  output logic [NUM_READ-1:0]            read_pending_o,
  input  logic                           write_enable_i,
  input  logic [SEL_WIDTH-1:0]           select_write_i,
  input  logic [DATA_WIDTH-1:0]          write_value_i,
  input  logic                           reserve_enable_i,
  input  logic [SEL_WIDTH-1:0]           reserve_sel_i,
  output logic                           busy_o
);

  localparam logic [SEL_WIDTH-1:0] LAST_INDEX = SEL_WIDTH'(NUM_REGS - 1);
  localparam logic                 ZERO_EN    = (ZERO_REG != 0);

  state_e               state_q, state_d;
  logic [SEL_WIDTH-1:0] count_q, count_d;
  logic                 clear_we;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic                  wr_accept;
  logic                  rsv_accept;
  logic [NUM_READ-1:0]   sb_pending;

  // ---------------- clear sequencer FSM ----------------
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= (CLEAR_ON_RESET != 0) ? STATE_CLEAR : STATE_READY;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      STATE_CLEAR: begin
        count_d = count_q + 1'b1;
        if (count_q == LAST_INDEX) begin
          state_d = STATE_READY;
          count_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy_o   = (state_q == STATE_CLEAR);
    clear_we = (state_q == STATE_CLEAR);
  end

  // ---------------- write / reserve qualification ----------------
  assign wr_accept  = !busy_o && write_enable_i &&
                      reg_valid(int'(select_write_i), NUM_REGS, ZERO_EN);
  assign rsv_accept = !busy_o && reserve_enable_i &&
                      reg_valid(int'(reserve_sel_i), NUM_REGS, ZERO_EN);

  // Storage is deliberately not reset; the clear sequencer zeroes it instead.
  always_ff @(posedge clock_i) begin
    if (clear_we)       regs_q[count_q]        <= '0;
    else if (wr_accept) regs_q[select_write_i] <= write_value_i;
  end

  register_scoreboard #(
    .NUM_REGS  (NUM_REGS),
    .SEL_WIDTH (SEL_WIDTH),
    .NUM_READ  (NUM_READ)
  ) u_scoreboard (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .set_en_i   (rsv_accept),
    .set_sel_i  (reserve_sel_i),
    .clr_en_i   (wr_accept),
    .clr_sel_i  (select_write_i),
    .read_sel_i (read_sel_i),
    .pending_o  (sb_pending)
  );

  // ---------------- read ports ----------------
  for (genvar k = 0; k < NUM_READ; k++) begin : g_port
    logic [SEL_WIDTH-1:0] sel;
    logic                 readable;
    logic                 bypass_hit;

    assign sel        = read_sel_i[k*SEL_WIDTH +: SEL_WIDTH];
    assign readable   = reg_valid(int'(sel), NUM_REGS, ZERO_EN);
    // wr_accept already excludes dropped writes, so a hit is always a real register.
    assign bypass_hit = (BYPASS != 0) && wr_accept && (sel == select_write_i);

    assign read_value_o[k*DATA_WIDTH +: DATA_WIDTH] =
      busy_o     ? '0 :
      bypass_hit ? write_value_i :
      readable   ? regs_q[sel] : '0;

    // A bypassed port already sees the producing value, so it is not a hazard.
    assign read_pending_o[k] = !busy_o && !bypass_hit && sb_pending[k];
  end

endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;

  logic        clk;
  logic        rst;
  logic [14:0] read_sel;
  logic [95:0] read_value;
  logic [2:0]  read_pending;
  logic        we;
  logic [4:0]  sw;
  logic [31:0] wv;
  logic        re;
  logic [4:0]  rs;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] model [31];
  logic [30:0] model_pend;

  register_file_mp #(
    .DATA_WIDTH(32), .NUM_REGS(31), .SEL_WIDTH(5), .NUM_READ(3),
    .BYPASS(1), .ZERO_REG(1), .CLEAR_ON_RESET(1)
  ) dut (
    .clock_i          (clk),
    .reset_i          (rst),
    .read_sel_i       (read_sel),
    .read_value_o     (read_value),
    .read_pending_o   (read_pending),
    .write_enable_i   (we),
    .select_write_i   (sw),
    .write_value_i    (wv),
    .reserve_enable_i (re),
    .reserve_sel_i    (rs),
    .busy_o           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rv(input int k);
    return read_value[k*32 +: 32];
  endfunction

  task automatic setsel(input int a, input int b, input int c);
    read_sel = {5'(c), 5'(b), 5'(a)};
  endtask

  // Reads every select 0..31 on all ports and compares against the model.
  task automatic check_all(input string tag);
    logic [31:0] ev;
    logic        ep;
    for (int r = 0; r < 32; r++) begin
      step();
      setsel(r, r, r);
      #1;
      ev = (r > 0 && r < 31) ? model[r] : 32'h0;
      ep = (r < 31) ? model_pend[r] : 1'b0;
      for (int k = 0; k < 3; k++) begin
        chk({tag, "_val"}, rv(k), ev);
        chk({tag, "_pend"}, 32'(read_pending[k]), 32'(ep));
      end
    end
  endtask

  // Entered at posedge+2 with reset just released; busy must hold 31 cycles.
  task automatic clear_phase(input int inject_at);
    for (int i = 0; i < 31; i++) begin
      #1;
      chk("clear_busy", 32'(busy), 32'd1);
      chk("clear_rd0", rv(0), 32'h0);
      chk("clear_pend", 32'(read_pending), 32'h0);
      if (i == inject_at) begin
        we = 1'b1; sw = 5'd3; wv = 32'h55;
        re = 1'b1; rs = 5'd3;
      end
      step();
      we = 1'b0; re = 1'b0;
    end
    #1;
    chk("ready_busy", 32'(busy), 32'd0);
    for (int r = 0; r < 31; r++) model[r] = 32'h0;
    model_pend = '0;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; sw = '0; wv = '0; re = 1'b0; rs = '0;
    setsel(3, 0, 30);
    step(); step();
    #1;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_pend", 32'(read_pending), 32'h0);
    chk("rst_rd0", rv(0), 32'h0);
    step();
    rst = 1'b0;
    clear_phase(5);
    check_all("post_clear");

    // write with bypass
    step();
    setsel(7, 5, 6);
    we = 1'b1; sw = 5'd7; wv = 32'hDEADBEEF;
    #1;
    chk("bypass_p0", rv(0), 32'hDEADBEEF);
    chk("bypass_p1_other", rv(1), 32'h0);
    chk("bypass_p2_other", rv(2), 32'h0);
    step();
    we = 1'b0; model[7] = 32'hDEADBEEF;
    setsel(7, 7, 7);
    #1;
    chk("wr7_p0", rv(0), 32'hDEADBEEF);
    chk("wr7_p1", rv(1), 32'hDEADBEEF);
    chk("wr7_p2", rv(2), 32'hDEADBEEF);

    // dropped writes
    step();
    setsel(0, 7, 0);
    we = 1'b1; sw = 5'd0; wv = 32'h1234;
    #1;
    chk("zero_no_bypass", rv(0), 32'h0);
    chk("zero_other_port", rv(1), 32'hDEADBEEF);
    step();
    setsel(31, 31, 0);
    sw = 5'd31; wv = 32'h99;
    #1;
    chk("oor_no_bypass", rv(0), 32'h0);
    step();
    we = 1'b0;
    check_all("dropped");

    // scoreboard
    step();
    setsel(5, 4, 4);
    re = 1'b1; rs = 5'd4;
    #1;
    chk("rsv_same_cycle", 32'(read_pending[1]), 32'd0);
    step();
    re = 1'b0;
    #1;
    chk("rsv_p1", 32'(read_pending[1]), 32'd1);
    chk("rsv_p2", 32'(read_pending[2]), 32'd1);
    chk("rsv_p0_other", 32'(read_pending[0]), 32'd0);
    step();
    we = 1'b1; sw = 5'd4; wv = 32'hA5;
    #1;
    chk("rsv_bypass_pend", 32'(read_pending[1]), 32'd0);
    chk("rsv_bypass_val", rv(1), 32'hA5);
    step();
    we = 1'b0; model[4] = 32'hA5;
    #1;
    chk("wr_clears_pend", 32'(read_pending[1]), 32'd0);
    chk("wr4_val", rv(1), 32'hA5);
    step();
    re = 1'b1; rs = 5'd4;
    we = 1'b1; sw = 5'd4; wv = 32'hB6;
    step();
    re = 1'b0; we = 1'b0;
    model[4] = 32'hB6; model_pend[4] = 1'b1;
    #1;
    chk("set_wins_pend", 32'(read_pending[1]), 32'd1);
    chk("set_wins_val", rv(1), 32'hB6);
    step();
    re = 1'b1; rs = 5'd0;
    step();
    rs = 5'd31;
    step();
    re = 1'b0;
    setsel(0, 4, 0);
    #1;
    chk("rsv_zero_pend", 32'(read_pending[0]), 32'd0);
    chk("rsv4_still", 32'(read_pending[1]), 32'd1);

    // three ports at once
    step();
    we = 1'b1; sw = 5'd1; wv = 32'h11;
    step();
    sw = 5'd2; wv = 32'h22;
    step();
    we = 1'b0; model[1] = 32'h11; model[2] = 32'h22;
    setsel(1, 2, 1);
    #1;
    chk("multi_p0", rv(0), 32'h11);
    chk("multi_p1", rv(1), 32'h22);
    chk("multi_p2", rv(2), 32'h11);
    check_all("before_reset");

    // fill, then reset mid-clear
    step();
    we = 1'b1; sw = 5'd8; wv = 32'hFFFFFFFF;
    step();
    sw = 5'd9;
    step();
    we = 1'b0;
    re = 1'b1; rs = 5'd10;
    setsel(8, 9, 8);
    #1;
    chk("fill_p0", rv(0), 32'hFFFFFFFF);
    chk("fill_p1", rv(1), 32'hFFFFFFFF);
    step();
    re = 1'b0;
    setsel(10, 10, 10);
    #1;
    chk("rsv10", 32'(read_pending[0]), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("clear1_busy", 32'(busy), 32'd1);
      step();
    end
    rst = 1'b1;
    #1;
    chk("midclear_rst_busy", 32'(busy), 32'd1);
    step();
    rst = 1'b0;
    setsel(8, 9, 10);
    clear_phase(-1);
    check_all("post_reset2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
